// File: rtl/ncl_rx_bridge.sv
// ncl_rx_bridge: synchronises a dual-rail NCL bundle, captures each stable DATA
// wavefront into a single-rail FIFO and drives the stage acknowledge.
module ncl_rx_bridge #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 2,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] ncl_in,
    output logic        ncl_ack,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_soma,
    output logic        out_zero,
    output logic        out_neg,
    output logic        out_of,
    output logic        err_illegal
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [2:0] SC = 3'(STABLE_CYCLES);
    localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

    typedef enum logic {WAIT_DATA = 1'b0, WAIT_NULL = 1'b1} state_t;

    state_t        state, state_n;
    logic [13:0]   sync_q [SYNC_STAGES];
    logic [13:0]   s, prev;
    logic [6:0]    r1, r0;
    logic [2:0]    cnt, run;
    logic          is_ill, is_null, is_comp, qual, space, push, pop;
    logic [6:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= ncl_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        r1 = '0;
        r0 = '0;
        for (int k = 0; k < 7; k++) begin
            r1[k] = s[2*k+1];
            r0[k] = s[2*k];
        end
    end

    assign is_ill  = |(r1 & r0);
    assign is_null = ~|(r1 | r0);
    assign is_comp = &(r1 ^ r0);
    // run counts this sample plus the identical samples already seen before it
    assign run     = (s == prev && cnt != 3'd0) ? cnt + 3'd1 : 3'd1;
    assign qual    = (is_comp || is_null) && run >= SC;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev        <= '0;
            cnt         <= '0;
            err_illegal <= 1'b0;
        end else begin
            prev        <= s;
            cnt         <= !(is_comp || is_null) ? 3'd0 : (run > SC ? SC : run);
            err_illegal <= err_illegal | is_ill;
        end
    end

    assign pop   = out_valid && out_ready;
    assign space = count < DEPTH || pop;

    always_comb begin
        state_n = state;
        push    = 1'b0;
        if (state == WAIT_DATA) begin
            push    = qual && is_comp && space;
            state_n = push ? WAIT_NULL : WAIT_DATA;
        end else begin
            state_n = (qual && is_null) ? WAIT_DATA : WAIT_NULL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_DATA;
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            state <= state_n;
            wp    <= wp + AW'(push);
            rp    <= rp + AW'(pop);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= r1;
    end

    assign ncl_ack   = state;
    assign out_valid = count != '0;
    assign {out_of, out_neg, out_zero, out_soma} = out_valid ? mem[rp] : 7'd0;
endmodule

// File: tb/tb_ncl_rx_bridge.sv
// tb_ncl_rx_bridge: acts as the NCL stage and the consumer around ncl_rx_bridge,
// checking every popped result against a queue of the wavefronts sent.
module tb_ncl_rx_bridge;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [13:0] ncl_in = '0;
    logic        ncl_ack, out_valid, out_zero, out_neg, out_of, err_illegal;
    logic        out_ready = 1'b0;
    logic [3:0]  out_soma;
    int          total = 0;
    int          bad = 0;
    bit          ready_mode = 1'b0;
    logic [6:0]  exp_q [$];

    ncl_rx_bridge dut (
        .clk(clk), .rst(rst), .ncl_in(ncl_in), .ncl_ack(ncl_ack),
        .out_valid(out_valid), .out_ready(out_ready), .out_soma(out_soma),
        .out_zero(out_zero), .out_neg(out_neg), .out_of(out_of),
        .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] enc(input logic [6:0] d);
        logic [13:0] r;
        for (int k = 0; k < 7; k++) begin
            r[2*k+1] = d[k];
            r[2*k]   = ~d[k];
        end
        return r;
    endfunction

    function automatic logic [6:0] head();
        return {out_of, out_neg, out_zero, out_soma};
    endfunction

    // Checks the head about to be popped at the coming edge, then advances to the next negedge.
    task automatic cyc();
        if (ready_mode) out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected got=%h want=nothing", head());
            end else begin
                if (head() !== exp_q[0]) begin
                    bad++;
                    $display("FAIL pop_data got=%h want=%h", head(), exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
        if (!out_valid) begin
            total++;
            if (head() !== 7'd0) begin
                bad++;
                $display("FAIL idle_zero got=%h want=00", head());
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_ack(input logic v);
        int n = 0;
        while (ncl_ack !== v && n < 100) begin
            cyc();
            n++;
        end
        total++;
        if (ncl_ack !== v) begin
            bad++;
            $display("FAIL ack_timeout got=%b want=%b", ncl_ack, v);
        end
    endtask

    task automatic test_reset();
        ready_mode = 1'b0;
        out_ready  = 1'b0;
        rst = 1'b1;
        cyc();
        total++;
        if ({ncl_ack, out_valid, head(), err_illegal} !== 10'd0) begin
            bad++;
            $display("FAIL reset_state got=%b want=0", {ncl_ack, out_valid, head(), err_illegal});
        end
        rst = 1'b0;
        exp_q.delete();
        ncl_in = '0;
        repeat (4) cyc();
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        ncl_in = enc(7'h05);
        exp_q.push_back(7'h05);
        repeat (3) cyc();
        total++;
        if (ncl_ack !== 1'b0) begin
            bad++;
            $display("FAIL single_early_ack got=%b want=0", ncl_ack);
        end
        cyc();
        total++;
        if (ncl_ack !== 1'b1 || out_valid !== 1'b1 || out_soma !== 4'b0101) begin
            bad++;
            $display("FAIL single_capture got=%b%b%h want=115", ncl_ack, out_valid, out_soma);
        end
        ncl_in = '0;
        cyc();
        total++;
        if (out_valid !== 1'b0 || ncl_ack !== 1'b1) begin
            bad++;
            $display("FAIL single_one_cycle got=%b%b want=01", out_valid, ncl_ack);
        end
        cyc();
        cyc();
        total++;
        if (ncl_ack !== 1'b1) begin
            bad++;
            $display("FAIL single_null_early got=%b want=1", ncl_ack);
        end
        cyc();
        total++;
        if (ncl_ack !== 1'b0) begin
            bad++;
            $display("FAIL single_null_drop got=%b want=0", ncl_ack);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_skew();
        logic [6:0]  d = 7'($urandom);
        logic [13:0] v = enc(d);
        out_ready = 1'b0;
        v[13:12] = 2'b00;
        ncl_in = v;
        repeat (3) cyc();
        ncl_in = enc(d);
        exp_q.push_back(d);
        repeat (2) cyc();
        total++;
        if (ncl_ack !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL skew_early got=%b%b want=00", ncl_ack, out_valid);
        end
        wait_ack(1'b1);
        ncl_in = '0;
        wait_ack(1'b0);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL skew_entries got=%b/%0d want=0/0", out_valid, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [6:0] d [3];
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d[i] = 7'($urandom);
            ncl_in = enc(d[i]);
            exp_q.push_back(d[i]);
            if (i < 2) begin
                wait_ack(1'b1);
                ncl_in = '0;
                wait_ack(1'b0);
            end
        end
        repeat (8) cyc();
        total++;
        if (ncl_ack !== 1'b0 || out_valid !== 1'b1 || head() !== d[0]) begin
            bad++;
            $display("FAIL bp_hold got=%b%b%h want=01%h", ncl_ack, out_valid, head(), d[0]);
        end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        total++;
        if (ncl_ack !== 1'b1 || head() !== d[1]) begin
            bad++;
            $display("FAIL bp_capture got=%b%h want=1%h", ncl_ack, head(), d[1]);
        end
        ncl_in = '0;
        wait_ack(1'b0);
        out_ready = 1'b1;
        repeat (3) cyc();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL bp_drain got=%b/%0d want=0/0", out_valid, exp_q.size());
        end
    endtask

    task automatic test_illegal();
        logic [13:0] v = enc(7'($urandom));
        v[5:4] = 2'b11;
        out_ready = 1'b0;
        ncl_in = v;
        repeat (6) cyc();
        total++;
        if (err_illegal !== 1'b1 || ncl_ack !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL illegal_flag got=%b%b%b want=100", err_illegal, ncl_ack, out_valid);
        end
        ncl_in = '0;
        repeat (6) cyc();
        total++;
        if (err_illegal !== 1'b1) begin
            bad++;
            $display("FAIL illegal_sticky got=%b want=1", err_illegal);
        end
        test_reset();
    endtask

    task automatic test_reset_mid();
        logic [6:0] d = 7'($urandom);
        out_ready = 1'b0;
        ncl_in = enc(d);
        exp_q.push_back(d);
        wait_ack(1'b1);
        rst = 1'b1;
        cyc();
        total++;
        if ({ncl_ack, out_valid, head(), err_illegal} !== 10'd0) begin
            bad++;
            $display("FAIL mid_reset got=%b want=0", {ncl_ack, out_valid, head(), err_illegal});
        end
        rst = 1'b0;
        exp_q.delete();
        exp_q.push_back(d);
        wait_ack(1'b1);
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL mid_recapture got=%b want=1", out_valid);
        end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        ncl_in = '0;
        wait_ack(1'b0);
    endtask

    task automatic test_glitch();
        logic [6:0]  d = 7'($urandom);
        logic [13:0] v = enc(d);
        out_ready = 1'b0;
        ncl_in = v;
        cyc();
        v[7:6] = 2'b00;
        ncl_in = v;
        repeat (8) cyc();
        total++;
        if (ncl_ack !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL glitch_capture got=%b%b want=00", ncl_ack, out_valid);
        end
        ncl_in = '0;
        repeat (4) cyc();
    endtask

    task automatic test_random();
        ready_mode = 1'b1;
        for (int i = 0; i < 30; i++) begin
            logic [6:0] d = 7'($urandom);
            ncl_in = enc(d);
            exp_q.push_back(d);
            wait_ack(1'b1);
            repeat ($urandom_range(0, 3)) cyc();
            ncl_in = '0;
            wait_ack(1'b0);
            repeat ($urandom_range(0, 2)) cyc();
        end
        ready_mode = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) cyc();
        cyc();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL random_drain got=%b/%0d want=0/0", out_valid, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_skew();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_glitch();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
